// File: rtl/gamma_pkg.sv
// Shared types and default sizing for the gamma-cycle controller slice.
package gamma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESET  = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } gamma_state_e;

  localparam int NUM_NEURONS_DEF = 16;
  localparam int TIME_W_DEF      = 5;
  localparam int WINDOW_DEF      = 24;
  localparam int RST_CYCLES_DEF  = 4;
  localparam int IDX_W_DEF       = $clog2(NUM_NEURONS_DEF);

endpackage

// File: rtl/gamma_cycle_ctrl_if.sv
// Result handshake between the gamma-cycle controller and the learning/readout logic.
interface gamma_cycle_ctrl_if #(
  parameter int NUM_NEURONS = 16,
  parameter int TIME_W      = 5
) ();
  localparam int IDX_W = $clog2(NUM_NEURONS);

  logic              result_valid;
  logic              result_ready;
  logic [IDX_W-1:0]  winner_idx;
  logic [TIME_W-1:0] winner_time;
  logic              no_spike;

  modport master (
    output result_valid, winner_idx, winner_time, no_spike,
    input  result_ready
  );

  modport slave (
    input  result_valid, winner_idx, winner_time, no_spike,
    output result_ready
  );
endinterface

// File: rtl/first_spike_enc.sv
// Lowest-index detector over an active-low spike vector.
module first_spike_enc #(
  parameter int NUM_NEURONS = 16,
  parameter int IDX_W       = 4
) (
  input  logic [NUM_NEURONS-1:0] spikes_n,
  output logic                   any_spike,
  output logic [IDX_W-1:0]       idx
);

  // Scanning downward lets the lowest low bit overwrite any higher one.
  always_comb begin
    any_spike = ~&spikes_n;
    idx       = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (!spikes_n[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/gamma_cycle_ctrl.sv
// Gamma-cycle sequencer: hold column in reset, release, time-stamp first spike, report.
// GAMMA_FULL_WINDOW_EN: run the whole window and expose an accumulated spike_mask.
module gamma_cycle_ctrl
  import gamma_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int TIME_W      = TIME_W_DEF,
  parameter int WINDOW      = WINDOW_DEF,
  parameter int RST_CYCLES  = RST_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   col_rst,
  input  logic [NUM_NEURONS-1:0] spikes_out,
`ifdef GAMMA_FULL_WINDOW_EN
  output logic [NUM_NEURONS-1:0] spike_mask,
`endif
  gamma_cycle_ctrl_if.master     res
);

  localparam int IDX_W  = $clog2(NUM_NEURONS);
  localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [TIME_W-1:0] T_LAST    = TIME_W'(WINDOW - 1);
  localparam logic [TIME_W-1:0] T_NONE    = TIME_W'(WINDOW);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RST_CYCLES - 1);

  gamma_state_e      state;
  logic [RCNT_W-1:0] rcnt;
  logic [TIME_W-1:0] t;
  logic              result_valid;
  logic [IDX_W-1:0]  winner_idx;
  logic [TIME_W-1:0] winner_time;
  logic              no_spike;
  logic              any_spike;
  logic [IDX_W-1:0]  enc_idx;
`ifdef GAMMA_FULL_WINDOW_EN
  logic              captured;
`endif

  first_spike_enc #(
    .NUM_NEURONS(NUM_NEURONS),
    .IDX_W      (IDX_W)
  ) u_enc (
    .spikes_n (spikes_out),
    .any_spike(any_spike),
    .idx      (enc_idx)
  );

  assign res.result_valid = result_valid;
  assign res.winner_idx   = winner_idx;
  assign res.winner_time  = winner_time;
  assign res.no_spike     = no_spike;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      col_rst      <= 1'b1;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      winner_idx   <= '0;
      winner_time  <= '0;
      no_spike     <= 1'b0;
      rcnt         <= '0;
      t            <= '0;
`ifdef GAMMA_FULL_WINDOW_EN
      captured     <= 1'b0;
      spike_mask   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RESET;
            busy  <= 1'b1;
            rcnt  <= '0;
          end
        end
        RESET: begin
          if (rcnt == RCNT_LAST) begin
            state   <= RUN;
            col_rst <= 1'b0;
            t       <= '0;
`ifdef GAMMA_FULL_WINDOW_EN
            captured   <= 1'b0;
            spike_mask <= '0;
`endif
          end else begin
            rcnt <= rcnt + RCNT_W'(1);
          end
        end
        RUN: begin
`ifdef GAMMA_FULL_WINDOW_EN
          spike_mask <= spike_mask | ~spikes_out;
          if (any_spike && !captured) begin
            captured    <= 1'b1;
            winner_idx  <= enc_idx;
            winner_time <= t;
          end
          if (t == T_LAST) begin
            state        <= REPORT;
            col_rst      <= 1'b1;
            result_valid <= 1'b1;
            no_spike     <= !captured && !any_spike;
            if (!captured && !any_spike) begin
              winner_idx  <= '0;
              winner_time <= T_NONE;
            end
          end else begin
            t <= t + TIME_W'(1);
          end
`else
          // The column is cleared in the same edge the winner is latched.
          if (any_spike) begin
            winner_idx   <= enc_idx;
            winner_time  <= t;
            no_spike     <= 1'b0;
            state        <= REPORT;
            col_rst      <= 1'b1;
            result_valid <= 1'b1;
          end else if (t == T_LAST) begin
            winner_idx   <= '0;
            winner_time  <= T_NONE;
            no_spike     <= 1'b1;
            state        <= REPORT;
            col_rst      <= 1'b1;
            result_valid <= 1'b1;
          end else begin
            t <= t + TIME_W'(1);
          end
`endif
        end
        REPORT: begin
          if (res.result_ready) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gamma_cycle_ctrl.sv
// Directed bench for gamma_cycle_ctrl: vector table plus backpressure and mid-run reset sequences.
module tb_gamma_cycle_ctrl;
  import gamma_pkg::*;

  localparam int N   = 16;
  localparam int TW  = 5;
  localparam int WIN = 24;
  localparam int RC  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         busy;
  logic         col_rst;
  logic [N-1:0] spikes_out = '1;
`ifdef GAMMA_FULL_WINDOW_EN
  logic [N-1:0] spike_mask;
`endif

  gamma_cycle_ctrl_if #(.NUM_NEURONS(N), .TIME_W(TW)) res ();

  gamma_cycle_ctrl #(
    .NUM_NEURONS(N),
    .TIME_W     (TW),
    .WINDOW     (WIN),
    .RST_CYCLES (RC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .col_rst   (col_rst),
    .spikes_out(spikes_out),
`ifdef GAMMA_FULL_WINDOW_EN
    .spike_mask(spike_mask),
`endif
    .res       (res.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  typedef struct {
    string name;
    int    a;
    int    b;
    int    st;     // RUN cycle at which lines a and b go low; -1 means silence
    bit    pre;    // line a already low before start
    int    e_idx;
    int    e_time;
    int    e_ns;
  } vec_t;

  vec_t vecs[6];

  // Called at a negedge while IDLE; returns at the negedge of the first RUN cycle.
  task automatic start_cycle(input string nm);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < RC; i++) begin
      check({nm, "_rst_colrst"}, 32'(col_rst), 32'd1);
      check({nm, "_rst_valid"}, 32'(res.result_valid), 32'd0);
      if (i == 0) check({nm, "_rst_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
    end
    check({nm, "_run_colrst"}, 32'(col_rst), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int  c;
    bit  done;
    int  exp_lat;
    if (v.pre) spikes_out[v.a] = 1'b0;
    start_cycle(v.name);
    c = 0;
    done = 1'b0;
    while (!done && c < 40) begin
      if (c == v.st) begin
        spikes_out[v.a] = 1'b0;
        spikes_out[v.b] = 1'b0;
      end
      @(negedge clk);
      c++;
      if (res.result_valid === 1'b1) done = 1'b1;
    end
    exp_lat = (v.st < 0) ? WIN : v.st + 1;
    check({v.name, "_latency"}, 32'(c), 32'(exp_lat));
    check({v.name, "_idx"}, 32'(res.winner_idx), 32'(v.e_idx));
    check({v.name, "_time"}, 32'(res.winner_time), 32'(v.e_time));
    check({v.name, "_nospike"}, 32'(res.no_spike), 32'(v.e_ns));
    check({v.name, "_rep_colrst"}, 32'(col_rst), 32'd1);
    check({v.name, "_rep_busy"}, 32'(busy), 32'd1);
    spikes_out = '1;
    res.result_ready = 1'b1;
    @(negedge clk);
    check({v.name, "_done_valid"}, 32'(res.result_valid), 32'd0);
    check({v.name, "_done_busy"}, 32'(busy), 32'd0);
    res.result_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    res.result_ready = 1'b0;
    vecs[0] = '{"basic",   5,  5,  7, 1'b0,  5,   7, 0};
    vecs[1] = '{"tie",    12,  3,  2, 1'b0,  3,   2, 0};
    vecs[2] = '{"silence", 0,  0, -1, 1'b0,  0, WIN, 1};
    vecs[3] = '{"early",   9,  9,  0, 1'b1,  9,   0, 0};
    vecs[4] = '{"last",   15, 15, 23, 1'b0, 15,  23, 0};
    vecs[5] = '{"t0tie",  15,  0,  0, 1'b0,  0,   0, 0};

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_colrst", 32'(col_rst), 32'd1);
    check("reset_valid", 32'(res.result_valid), 32'd0);
    check("reset_idx", 32'(res.winner_idx), 32'd0);
    check("reset_time", 32'(res.winner_time), 32'd0);
    check("reset_nospike", 32'(res.no_spike), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Backpressure: result held while ready is low; start has no effect.
    start_cycle("bp");
    @(negedge clk);
    spikes_out[2] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      start = 1'b1;
      check("bp_hold", {res.result_valid, busy, col_rst, 5'(res.winner_idx), 8'(res.winner_time), res.no_spike},
            {1'b1, 1'b1, 1'b1, 5'd2, 8'd1, 1'b0});
      @(negedge clk);
    end
    start = 1'b0;
    spikes_out = '1;
    res.result_ready = 1'b1;
    @(negedge clk);
    check("bp_done_valid", 32'(res.result_valid), 32'd0);
    check("bp_done_busy", 32'(busy), 32'd0);
    res.result_ready = 1'b0;
    @(negedge clk);
    check("bp_no_restart", 32'(busy), 32'd0);
    check("bp_idle_colrst", 32'(col_rst), 32'd1);

    // Mid-run reset at t=5, then a spike that must not be reported.
    start_cycle("mid");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_colrst", 32'(col_rst), 32'd1);
    check("mid_valid", 32'(res.result_valid), 32'd0);
    check("mid_idx", 32'(res.winner_idx), 32'd0);
    check("mid_time", 32'(res.winner_time), 32'd0);
    rst = 1'b0;
    spikes_out[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mid_after", {30'd0, res.result_valid, busy}, 32'd0);
    end
    spikes_out = '1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
